present_key_sched_stream: RTL and testbench
===========================================

Name: present_key_sched_stream

Overview:
- Parametrised PRESENT key schedule generator supporting 80-bit and 128-bit keys.
- Emits all NUM_ROUNDS+1 64-bit round keys over a valid/ready stream to the round datapath.
  - Forward order (RK1..RK32) for encryption.
  - Reverse order (RK32..RK1) for decryption, using an internal round-key buffer.
- Replaces the free-running single-step key register with a controlled, back-pressurable engine that has its own round counter.

Parameters:
- KEY_SIZE, 80, key width; legal values 80 or 128 (elaboration error otherwise).
- NUM_ROUNDS, 31, number of schedule updates; NUM_ROUNDS+1 round keys produced.
- RK_W, 64, round-key width, taken as the top 64 bits of the key register.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a schedule; sampled only in IDLE
- decrypt  in  1  0 = forward order, 1 = reverse order; sampled with start
- key_in  in  KEY_SIZE  user key; sampled with start
- abort  in  1  synchronous; return to IDLE, drop rk_valid next cycle
- rk_ready  in  1  consumer accepts the round key
- rk_valid  out  1  rk_out/rk_round valid
- rk_out  out  RK_W  round key
- rk_round  out  6  round-key number, 1..NUM_ROUNDS+1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (rst=0, async): state=IDLE; rk_valid=0, rk_out=0, rk_round=0, busy=0, done=0; key register and counters cleared. Buffer contents are don't-care.
- Update step, where r is the round counter 1..NUM_ROUNDS:
  - 80-bit: K = K rotated left by 61; K[79:76] = S(K[79:76]); K[19:15] ^= r[4:0].
  - 128-bit: K = K rotated left by 61; K[127:124] = S(K[127:124]); K[123:120] = S(K[123:120]); K[66:62] ^= r[4:0].
  - The S-box is applied to the rotated value. The XOR is applied after the S-box.
- Round key i = K_i[KEY_SIZE-1 -: 64]. K_1 = key_in.
- States are IDLE, FWD, EXPAND, REV, DONE.
- IDLE:
  - start=1 and decrypt=0: load K=key_in, r=1; go to FWD. rk_valid=1 with RK1 and rk_round=1 on the next cycle (latency 1).
  - start=1 and decrypt=1: load K, write buf[0]=RK1, r=1; go to EXPAND.
- FWD:
  - rk_out/rk_round are held stable while rk_valid=1 and rk_ready=0.
  - On a handshake with rk_round < NUM_ROUNDS+1: apply the update step with the current r, increment r and rk_round. The next key is presented the following cycle, so back-to-back handshakes give 1 key per cycle.
  - On the handshake of rk_round = NUM_ROUNDS+1: go to DONE.
- EXPAND:
  - Each cycle applies the update step and writes buf[r] = new top 64 bits, then increments r.
  - Runs exactly NUM_ROUNDS cycles, ignoring rk_ready.
  - Then go to REV with a read pointer at NUM_ROUNDS.
  - rk_valid rises exactly NUM_ROUNDS+1 cycles after start is sampled.
- REV:
  - Presents buf[ptr] with rk_round = ptr+1.
  - A handshake decrements ptr. The handshake at ptr=0 goes to DONE.
  - Output is held under stall as in FWD.
- DONE: rk_valid=0, done=1 for one cycle, then IDLE.
- start while busy=1 is ignored; key_in/decrypt are not re-sampled.
- abort has priority over a handshake in the same cycle. It clears rk_valid and goes to IDLE with no done pulse.
- Reset mid-operation behaves identically to power-on reset.
- The round counter is wider than the 5-bit XOR field. Only r[4:0] is XORed; for NUM_ROUNDS=31 no wrap occurs.
- Buffer: NUM_ROUNDS+1 entries x 64, written only in IDLE-load and EXPAND, read only in REV.

Decomposition:
- Package present_ks_pkg holds:
  - the 4-bit S-box constant table;
  - the KEY_SIZE legal values;
  - the rotation amount 61;
  - the XOR-field LSB positions (15 for 80-bit, 62 for 128-bit);
  - the state enum.
- Sub-module present_ks_step is a combinational single update step (K, r -> K'), parametrised by KEY_SIZE and instancing the existing SBox once or twice. It is shared by FWD and EXPAND.

Test Plan:
- 80-bit, key=0, decrypt=0, rk_ready=1 -> RK1=0x0000000000000000, RK2=0xC000000000000000, RK3=0x5000180000000001; 32 handshakes, then done pulse.
- 128-bit, key=0, forward -> RK1=0x0000000000000000, RK2=0xCC00000000000000; rk_round runs 1..32.
- 80-bit, key=0, decrypt=1 -> rk_valid rises 32 cycles after start. The first rk_round=32, and the sequence equals the forward capture reversed; the last three are 0x5000180000000001, 0xC000000000000000, 0x0.
- Random rk_ready stalls, both modes, both key sizes -> rk_out/rk_round are stable while stalled, and no key is skipped or repeated.
- abort asserted at rk_round=10 (FWD) and during EXPAND -> rk_valid=0 next cycle, IDLE, no done pulse; a following start produces the correct RK1.
- rst low mid-REV -> all outputs are 0 immediately. start during busy is ignored, and the key_in change is not observed.

Source files
------------

// File: rtl/present_ks_pkg.sv
// Shared constants, state encoding and S-box lookup for the PRESENT key schedule.
package present_ks_pkg;

    localparam int KEY_SIZE_80  = 80;
    localparam int KEY_SIZE_128 = 128;

    // Left rotation applied to the whole key register on every update.
    localparam int ROT_AMT = 61;

    // LSB of the 5-bit round-counter XOR field inside the key register.
    localparam int XOR_LSB_80  = 15;
    localparam int XOR_LSB_128 = 62;

    localparam int RND_FIELD_W = 5;
    localparam int RK_ROUND_W  = 6;

    // PRESENT S-box; entry i lives in nibble i (S(0)=C ... S(F)=2).
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_EXPAND,
        ST_REV,
        ST_DONE
    } ks_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_key_sched_stream_if.sv
// Round-key stream from the key schedule to the round datapath.
interface present_key_sched_stream_if
    import present_ks_pkg::*;
#(
    parameter int RK_W = 64
);
    logic                  rk_valid;
    logic                  rk_ready;
    logic [RK_W-1:0]       rk_out;
    logic [RK_ROUND_W-1:0] rk_round;

    modport master (output rk_valid, output rk_out, output rk_round, input rk_ready);
    modport slave  (input rk_valid, input rk_out, input rk_round, output rk_ready);
endinterface

// File: rtl/present_ks_step.sv
// One combinational key-schedule update: rotate left 61, S-box the top
// nibble(s) of the rotated value, then XOR the round counter into its field.
module present_ks_step
    import present_ks_pkg::*;
#(
    parameter int KEY_SIZE = 80
) (
    input  logic [KEY_SIZE-1:0]    key_i,
    input  logic [RND_FIELD_W-1:0] rnd_i,
    output logic [KEY_SIZE-1:0]    key_o
);
    logic [KEY_SIZE-1:0] rot;

    assign rot = {key_i[KEY_SIZE-ROT_AMT-1:0], key_i[KEY_SIZE-1:KEY_SIZE-ROT_AMT]};

    if (KEY_SIZE == KEY_SIZE_80) begin : g_k80
        logic [3:0] s_hi;
        present_sbox u_sbox_hi (.x_i(rot[79:76]), .y_o(s_hi));
        assign key_o = {s_hi, rot[75:0]} ^ (KEY_SIZE'(rnd_i) << XOR_LSB_80);
    end else if (KEY_SIZE == KEY_SIZE_128) begin : g_k128
        logic [3:0] s_hi;
        logic [3:0] s_lo;
        present_sbox u_sbox_hi (.x_i(rot[127:124]), .y_o(s_hi));
        present_sbox u_sbox_lo (.x_i(rot[123:120]), .y_o(s_lo));
        assign key_o = {s_hi, s_lo, rot[119:0]} ^ (KEY_SIZE'(rnd_i) << XOR_LSB_128);
    end else begin : g_bad_key
        $error("present_ks_step: KEY_SIZE must be 80 or 128");
        assign key_o = rot;
    end
endmodule

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box.
module present_sbox
    import present_ks_pkg::*;
(
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);
    assign y_o = sbox4(x_i);
endmodule

// File: rtl/present_key_sched_stream.sv
// PRESENT key schedule engine: streams all round keys forward, or expands
// them into a buffer first and streams them in reverse for decryption.
module present_key_sched_stream
    import present_ks_pkg::*;
#(
    parameter int KEY_SIZE   = 80,
    parameter int NUM_ROUNDS = 31,
    parameter int RK_W       = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                decrypt,
    input  logic [KEY_SIZE-1:0] key_in,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    present_key_sched_stream_if.master rk_if
);
    localparam int AW = (NUM_ROUNDS > 0) ? $clog2(NUM_ROUNDS + 1) : 1;
    localparam logic [RK_ROUND_W-1:0] LAST_RK = RK_ROUND_W'(NUM_ROUNDS + 1);
    localparam logic [RK_ROUND_W-1:0] LAST_R  = RK_ROUND_W'(NUM_ROUNDS);

    if (KEY_SIZE != KEY_SIZE_80 && KEY_SIZE != KEY_SIZE_128) begin : g_bad_key
        $error("present_key_sched_stream: KEY_SIZE must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 62 || RK_W > KEY_SIZE) begin : g_bad_cfg
        $error("present_key_sched_stream: NUM_ROUNDS must be 1..62 and RK_W <= KEY_SIZE");
    end

    ks_state_e             state_q, state_d;
    logic [KEY_SIZE-1:0]   key_q, key_d;
    logic [RK_ROUND_W-1:0] rnd_q, rnd_d;
    logic [RK_ROUND_W-1:0] rk_round_q, rk_round_d;

    logic [RK_W-1:0]       rk_buf_q [NUM_ROUNDS+1];
    logic                  buf_we;
    logic [AW-1:0]         buf_waddr;
    logic [RK_W-1:0]       buf_wdata;
    logic [AW-1:0]         buf_raddr;

    logic [KEY_SIZE-1:0]   key_nxt;
    logic                  rk_valid;
    logic                  hs;
    logic [RK_W-1:0]       rk_out_c;

    present_ks_step #(.KEY_SIZE(KEY_SIZE)) u_step (
        .key_i (key_q),
        .rnd_i (rnd_q[RND_FIELD_W-1:0]),
        .key_o (key_nxt)
    );

    assign rk_valid  = (state_q == ST_FWD) || (state_q == ST_REV);
    assign hs        = rk_valid && rk_if.rk_ready;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    // In REV rk_round holds ptr+1, so the read pointer is derived from it.
    assign buf_raddr = AW'(rk_round_q - RK_ROUND_W'(1));

    // Next-state, key update and buffer-write decode.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        rnd_d      = rnd_q;
        rk_round_d = rk_round_q;
        buf_we     = 1'b0;
        buf_waddr  = AW'(rnd_q);
        buf_wdata  = key_nxt[KEY_SIZE-1 -: RK_W];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d      = key_in;
                    rnd_d      = RK_ROUND_W'(1);
                    rk_round_d = RK_ROUND_W'(1);
                    if (decrypt) begin
                        buf_we    = 1'b1;
                        buf_waddr = '0;
                        buf_wdata = key_in[KEY_SIZE-1 -: RK_W];
                        state_d   = ST_EXPAND;
                    end else begin
                        state_d   = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (hs) begin
                    if (rk_round_q == LAST_RK) begin
                        state_d = ST_DONE;
                    end else begin
                        key_d      = key_nxt;
                        rnd_d      = rnd_q + RK_ROUND_W'(1);
                        rk_round_d = rk_round_q + RK_ROUND_W'(1);
                    end
                end
            end
            ST_EXPAND: begin
                key_d  = key_nxt;
                rnd_d  = rnd_q + RK_ROUND_W'(1);
                buf_we = 1'b1;
                if (rnd_q == LAST_R) begin
                    state_d    = ST_REV;
                    rk_round_d = LAST_RK;
                end
            end
            ST_REV: begin
                if (hs) begin
                    if (rk_round_q == RK_ROUND_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rk_round_d = rk_round_q - RK_ROUND_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any handshake and suppresses the done pulse.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // Round-key output mux; zero whenever no key is being offered.
    always_comb begin
        rk_out_c = '0;
        if (state_q == ST_FWD) begin
            rk_out_c = key_q[KEY_SIZE-1 -: RK_W];
        end else if (state_q == ST_REV) begin
            rk_out_c = rk_buf_q[buf_raddr];
        end
    end

    assign rk_if.rk_valid = rk_valid;
    assign rk_if.rk_out   = rk_out_c;
    assign rk_if.rk_round = rk_valid ? rk_round_q : '0;

    // Control and key register state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            rnd_q      <= '0;
            rk_round_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            rnd_q      <= rnd_d;
            rk_round_q <= rk_round_d;
        end
    end

    // Round-key buffer for reverse order; contents need no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            rk_buf_q[buf_waddr] <= buf_wdata;
        end
    end
endmodule

// File: tb/tb_present_key_sched_stream.sv
// Directed bench for present_key_sched_stream with a round-key scoreboard.
module tb_present_key_sched_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start80 = 1'b0;
    logic         start128 = 1'b0;
    logic         decrypt = 1'b0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b0;
    logic [79:0]  key80 = '0;
    logic [127:0] key128 = '0;
    logic         busy80, done80, busy128, done128;

    present_key_sched_stream_if #(.RK_W(64)) if80 ();
    present_key_sched_stream_if #(.RK_W(64)) if128 ();
    assign if80.rk_ready  = rk_ready;
    assign if128.rk_ready = rk_ready;

    present_key_sched_stream #(.KEY_SIZE(80), .NUM_ROUNDS(31), .RK_W(64)) dut80 (
        .clk(clk), .rst(rst), .start(start80), .decrypt(decrypt), .key_in(key80),
        .abort(abort), .busy(busy80), .done(done80), .rk_if(if80)
    );
    present_key_sched_stream #(.KEY_SIZE(128), .NUM_ROUNDS(31), .RK_W(64)) dut128 (
        .clk(clk), .rst(rst), .start(start128), .decrypt(decrypt), .key_in(key128),
        .abort(abort), .busy(busy128), .done(done128), .rk_if(if128)
    );

    // Selected-DUT view used by the stream tasks.
    logic        sel128 = 1'b0;
    logic        m_valid, m_busy, m_done;
    logic [63:0] m_rk;
    logic [5:0]  m_round;
    always_comb begin
        if (sel128) begin
            m_valid = if128.rk_valid; m_rk = if128.rk_out; m_round = if128.rk_round;
            m_busy = busy128; m_done = done128;
        end else begin
            m_valid = if80.rk_valid; m_rk = if80.rk_out; m_round = if80.rk_round;
            m_busy = busy80; m_done = done80;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the key schedule.
    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic logic [127:0] ref_step(input logic [127:0] k, input int ks, input int r);
        logic [127:0] msk;
        logic [127:0] v;
        logic [4:0]   r5;
        msk = (ks == 80) ? ((128'd1 << 80) - 128'd1) : {128{1'b1}};
        v = ((k << 61) | (k >> (ks - 61))) & msk;
        v[ks-1 -: 4] = SB[v[ks-1 -: 4]];
        if (ks == 128) v[123:120] = SB[v[123:120]];
        r5 = r[4:0];
        v = v ^ ({123'd0, r5} << ((ks == 80) ? 15 : 62));
        return v;
    endfunction

    logic [63:0] exp_q[$];
    logic [5:0]  rnd_q[$];
    logic [63:0] cap [1:32];
    int          ncap;

    task automatic push_expected(input logic [127:0] key, input int ks, input bit dec);
        logic [63:0]  rk [1:32];
        logic [127:0] k;
        int           j;
        k = key;
        for (int i = 1; i <= 32; i++) begin
            rk[i] = 64'(k >> (ks - 64));
            if (i < 32) k = ref_step(k, ks, i);
        end
        for (int i = 1; i <= 32; i++) begin
            j = dec ? 33 - i : i;
            exp_q.push_back(rk[j]);
            rnd_q.push_back(6'(j));
        end
    endtask

    // Start one schedule and consume it, checking order, latency, stall hold and done.
    task automatic run_stream(input bit big, input logic [127:0] key, input bit dec,
                              input bit stall, input bit intrude);
        int          ks, lat, cyc;
        bit          seen, held_v;
        logic [63:0] held_rk;
        logic [5:0]  held_rnd;
        ks = big ? 128 : 80;
        if (!big) key = key & ((128'd1 << 80) - 128'd1);
        @(negedge clk);
        sel128 = big;
        decrypt = dec;
        if (big) begin key128 = key; start128 = 1'b1; end
        else begin key80 = key[79:0]; start80 = 1'b1; end
        push_expected(key, ks, dec);
        @(negedge clk);
        start80 = 1'b0; start128 = 1'b0;
        ncap = 0; lat = 1; cyc = 0; seen = 0; held_v = 0; held_rk = '0; held_rnd = '0;
        while (exp_q.size() > 0 && cyc < 400) begin
            cyc++;
            if (intrude && cyc == 3) begin
                if (big) begin key128 = ~key; start128 = 1'b1; end
                else begin key80 = ~key[79:0]; start80 = 1'b1; end
                decrypt = ~dec;
            end
            if (intrude && cyc == 4) begin start80 = 1'b0; start128 = 1'b0; end
            if (!seen) begin
                if (m_valid) begin seen = 1; chk("latency", lat, dec ? 32 : 1); end
                else lat++;
            end
            if (held_v) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_rk", m_rk, held_rk);
                chk("stall_round", m_round, held_rnd);
            end
            rk_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            held_v = m_valid && !rk_ready;
            held_rk = m_rk;
            held_rnd = m_round;
            if (m_valid && rk_ready) begin
                chk("rk_out", m_rk, exp_q.pop_front());
                chk("rk_round", m_round, rnd_q.pop_front());
                if (ncap < 32) begin ncap++; cap[ncap] = m_rk; end
            end
            @(negedge clk);
        end
        chk("stream_drained", exp_q.size(), 0);
        exp_q.delete(); rnd_q.delete();
        rk_ready = 1'b0;
        chk("done_pulse", m_done, 1);
        chk("valid_after_last", m_valid, 0);
        @(negedge clk);
        chk("done_single", m_done, 0);
        chk("idle_after_done", m_busy, 0);
    endtask

    int n;

    initial begin
        // Power-on reset state of both instances.
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid80", if80.rk_valid, 0);
        chk("rst_rk80", if80.rk_out, 0);
        chk("rst_round80", if80.rk_round, 0);
        chk("rst_busy80", busy80, 0);
        chk("rst_done80", done80, 0);
        chk("rst_valid128", if128.rk_valid, 0);
        chk("rst_busy128", busy128, 0);
        rst = 1'b1;

        // 80-bit zero key, forward.
        run_stream(1'b0, 128'd0, 1'b0, 1'b0, 1'b0);
        chk("k80_count", ncap, 32);
        chk("k80_rk1", cap[1], 64'h0);
        chk("k80_rk2", cap[2], 64'hC000000000000000);
        chk("k80_rk3", cap[3], 64'h5000180000000001);

        // 128-bit zero key, forward.
        run_stream(1'b1, 128'd0, 1'b0, 1'b0, 1'b0);
        chk("k128_rk1", cap[1], 64'h0);
        chk("k128_rk2", cap[2], 64'hCC00000000000000);

        // 80-bit zero key, reverse.
        run_stream(1'b0, 128'd0, 1'b1, 1'b0, 1'b0);
        chk("rev80_rk30", cap[30], 64'h5000180000000001);
        chk("rev80_rk31", cap[31], 64'hC000000000000000);
        chk("rev80_rk32", cap[32], 64'h0);

        // Random keys with random back-pressure, both modes and sizes.
        for (int t = 0; t < 2; t++) begin
            run_stream(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
            run_stream(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0);
            run_stream(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
            run_stream(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0);
        end

        // Abort in FWD at round 10 (with a handshake offered the same cycle).
        @(negedge clk);
        sel128 = 1'b0; decrypt = 1'b0; key80 = 80'h0123_4567_89AB_CDEF_1357; start80 = 1'b1;
        @(negedge clk);
        start80 = 1'b0; rk_ready = 1'b1; n = 0;
        while (!(m_valid && m_round == 6'd10) && n < 60) begin @(negedge clk); n++; end
        chk("abort_fwd_reach", m_round, 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; rk_ready = 1'b0;
        chk("abort_fwd_valid", m_valid, 0);
        chk("abort_fwd_busy", m_busy, 0);
        chk("abort_fwd_done", m_done, 0);
        @(negedge clk);
        chk("abort_fwd_nodone", m_done, 0);
        run_stream(1'b0, 128'hFEDC_BA98_7654_3210_FFFF, 1'b0, 1'b0, 1'b0);

        // Abort during EXPAND.
        @(negedge clk);
        sel128 = 1'b1; decrypt = 1'b1; key128 = 128'h1; start128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0;
        repeat (5) @(negedge clk);
        chk("expand_busy", m_busy, 1);
        chk("expand_novalid", m_valid, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_exp_valid", m_valid, 0);
        chk("abort_exp_busy", m_busy, 0);
        chk("abort_exp_done", m_done, 0);
        repeat (30) @(negedge clk);
        chk("abort_exp_stays_idle", m_valid, 0);
        run_stream(1'b1, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b0, 1'b0, 1'b0);

        // start while busy is ignored and key_in changes are not observed.
        run_stream(1'b0, 128'hA5A5_5A5A_0F0F_F0F0_3C3C, 1'b0, 1'b1, 1'b1);
        run_stream(1'b1, 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of REV.
        @(negedge clk);
        sel128 = 1'b1; decrypt = 1'b1; key128 = 128'h55; start128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0; rk_ready = 1'b0; n = 0;
        while (!m_valid && n < 60) begin @(negedge clk); n++; end
        chk("rev_reach", m_valid, 1);
        chk("rev_first_round", m_round, 32);
        rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        rk_ready = 1'b0;
        chk("rev_mid_round", m_round, 30);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_rk", m_rk, 0);
        chk("mid_rst_round", m_round, 0);
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_done", m_done, 0);
        @(negedge clk);
        rst = 1'b1;
        run_stream(1'b1, 128'h55, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
